ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

Synthesizable AHB-to-APB bridge that consumes the AHB master's single read/write transfers and re-issues them as APB2 setup/enable transfers to up to three peripherals. It sits directly downstream of the AHB master in the bridge testbench and is the DUT that the master drives. Each transfer is held on AHB with wait states via Hreadyout until the APB access completes. Every transfer returns an OKAY response.

## Interface
Parameters:
- none; the peripheral map is fixed (see Operation).

Ports:
- Hclk  in  1  single system clock, rising edge.
- Hresetn  in  1  asynchronous, active-low reset.
- Htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  in  32  AHB address (address phase).
- Hwrite  in  1  1 = write, 0 = read (address phase).
- Hwdata  in  32  write data, valid in the cycle after the address phase.
- Hreadyin  in  1  AHB bus ready from the master/interconnect.
- Hreadyout  out  1  0 = insert wait state.
- Hresp  out  2  always 2'b00 (OKAY).
- Hrdata  out  32  read data to the master.
- Pselx  out  3  one-hot APB peripheral select.
- Penable  out  1  APB enable strobe.
- Pwrite  out  1  APB direction.
- Paddr  out  32  APB address.
- Pwdata  out  32  APB write data.
- Prdata  in  32  APB read data.

## Operation
- valid = Hreadyin & Htrans[1] & (Haddr ≥ 32'h8000_0000) & (Haddr ≤ 32'h8BFF_FFFF). BUSY and IDLE transfers, and out-of-range addresses, are ignored silently.
- Peripheral decode from the captured address:
  - 8000_0000–83FF_FFFF → Pselx=001
  - 8400_0000–87FF_FFFF → Pselx=010
  - 8800_0000–8BFF_FFFF → Pselx=100
- Address capture: when valid and Hreadyout=1, Haddr and Hwrite are registered into addr_q and write_q.
- FSM states: IDLE, WDATA, W_SETUP, W_ENABLE, R_SETUP, R_ENABLE.
  - Accepting states are IDLE, W_ENABLE and R_ENABLE. In each: if valid & Hwrite, go to WDATA; if valid & !Hwrite, go to R_SETUP; otherwise go to IDLE.
  - WDATA: Hreadyout=0; latch Hwdata into wdata_q; go to W_SETUP.
  - W_SETUP: Pselx=decode(addr_q), Pwrite=1, Paddr=addr_q, Pwdata=wdata_q, Penable=0, Hreadyout=0; go to W_ENABLE.
  - W_ENABLE: Pselx, Paddr, Pwrite and Pwdata are held; Penable=1; Hreadyout=1.
  - R_SETUP: Pselx=decode(addr_q), Pwrite=0, Paddr=addr_q, Penable=0, Hreadyout=0; go to R_ENABLE.
  - R_ENABLE: Penable=1, Hreadyout=1, Hrdata=Prdata (combinational passthrough).
- APB outputs are registered. There is no combinational path from AHB inputs to Psel/Penable/Paddr/Pwrite/Pwdata.
- In IDLE, WDATA and the setup states Hrdata=32'h0. In all other non-access states Pselx=000 and Penable=0; Paddr, Pwdata and Pwrite hold their last values.
- Back-to-back transfers: a new address phase presented during W_ENABLE or R_ENABLE is accepted in that cycle. There are no idle APB cycles between transfers beyond the setup phase.
- Reset (async, any state): state=IDLE, Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hresp=00, Hrdata=0, addr_q=0, write_q=0, wdata_q=0. An in-flight APB access is abandoned with no completion. Operation resumes on the first rising edge after deassertion.

## Timing
- Write, with address phase in cycle 0:
  - Cycle 1: WDATA, Hreadyout=0.
  - Cycle 2: W_SETUP, Psel asserted.
  - Cycle 3: W_ENABLE, Penable=1, Hreadyout=1; the data phase ends.
  - Latency from address to APB enable is 3 cycles. Total data-phase wait states: 2.
- Read, with address phase in cycle 0:
  - Cycle 1: R_SETUP, Hreadyout=0.
  - Cycle 2: R_ENABLE, Hrdata=Prdata, Hreadyout=1.
  - Wait states: 1.
- Hwdata is sampled only at the end of the WDATA cycle. The master must hold it while Hreadyout=0.
- Pselx stays stable from setup through enable; Penable is high for exactly one cycle per access.

## Test plan
- Reset: assert Hresetn=0 mid W_SETUP → Pselx=000, Penable=0 and Hreadyout=1 immediately, with no Hclk edge needed; after release, state is IDLE.
- Single write, Haddr=32'h8000_0001 with Hwdata=32'hA3 one cycle later → Pselx=001 in cycle 2 and Penable=1 in cycle 3; Paddr=8000_0001, Pwdata=0000_00A3, Pwrite=1; Hreadyout low for cycles 1–2.
- Single read, Haddr=32'h8000_00A2 with Prdata=32'hDEAD_BEEF → Pselx=001, Pwrite=0 in cycle 1; Penable=1 and Hrdata=DEAD_BEEF with Hreadyout=1 in cycle 2.
- Decode: reads at 8400_0010 and 8800_0020 → Pselx=010 and 100 respectively. A read at 9000_0000, or Htrans=01 to 8000_0000, produces no Psel activity, Hreadyout stays 1 and Hresp=00.
- Back-to-back: a write to 8000_0004 followed by a read to 8400_0008 presented during W_ENABLE → R_SETUP on the next cycle with no IDLE cycle in between, and the read completes correctly.
- Hreadyin=0 with Htrans=10 and an in-range address → transfer ignored, FSM stays IDLE.

Source files
------------

// File: rtl/ahb_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_if
// Purpose : groups the AHB slave-side and APB master-side signals of the
//           AHB-to-APB bridge into one bundle.
// Modports:
//   slave  - bridge view: consumes AHB transfer and APB read data,
//            drives AHB response and APB request signals.
//   master - environment view (AHB master plus APB peripherals), the mirror
//            image of the slave modport.
// Signals : Htrans[1:0], Haddr[31:0], Hwrite, Hwdata[31:0], Hreadyin,
//           Hreadyout, Hresp[1:0], Hrdata[31:0], Pselx[2:0], Penable,
//           Pwrite, Paddr[31:0], Pwdata[31:0], Prdata[31:0]
// ---------------------------------------------------------------------------
interface ahb_apb_bridge_if;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport slave (
        input  Htrans, Haddr, Hwrite, Hwdata, Hreadyin, Prdata,
        output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport master (
        output Htrans, Haddr, Hwrite, Hwdata, Hreadyin, Prdata,
        input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
// Purpose : converts single AHB read/write transfers into APB2 setup/enable
//           accesses to three fixed 64 MiB peripheral windows starting at
//           8000_0000. The AHB data phase is stretched via Hreadyout until
//           the APB enable cycle; every transfer answers OKAY.
// Ports   :
//   Hclk    - system clock, rising edge
//   Hresetn - asynchronous active-low reset
//   bus     - ahb_apb_bridge_if.slave (AHB slave side + APB master side)
// ---------------------------------------------------------------------------
module ahb_apb_bridge (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    ahb_apb_bridge_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WDATA    = 3'd1,
        ST_W_SETUP  = 3'd2,
        ST_W_ENABLE = 3'd3,
        ST_R_SETUP  = 3'd4,
        ST_R_ENABLE = 3'd5
    } state_t;

    // One-hot select for the three 64 MiB windows; bits [27:26] pick the slot.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        case (addr[27:26])
            2'b00:   sel = 3'b001;
            2'b01:   sel = 3'b010;
            2'b10:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr_q,  w_addr_nxt;
    logic        r_write_q, w_write_nxt;
    logic [31:0] r_wdata_q, w_wdata_nxt;
    logic [2:0]  r_pselx,   w_pselx_nxt;
    logic        r_penable, w_penable_nxt;
    logic        r_pwrite,  w_pwrite_nxt;
    logic [31:0] r_paddr,   w_paddr_nxt;
    logic [31:0] r_pwdata,  w_pwdata_nxt;
    logic        r_hreadyout, w_hreadyout_nxt;
    logic        w_valid;
    logic        w_accepting;
    logic [31:0] w_hrdata;

    // 8000_0000..8BFF_FFFF: top nibble 8 and not the unused fourth slot.
    assign w_valid = bus.Hreadyin & bus.Htrans[1] &
                     (bus.Haddr[31:28] == 4'h8) & (bus.Haddr[27:26] != 2'b11);

    assign w_accepting = (r_state == ST_IDLE) | (r_state == ST_W_ENABLE) |
                         (r_state == ST_R_ENABLE);

    // Next-state and next-register-value decode; APB outputs are computed one
    // cycle ahead so they leave the bridge straight from flops.
    always_comb begin
        w_state_nxt     = ST_IDLE;
        w_addr_nxt      = r_addr_q;
        w_write_nxt     = r_write_q;
        w_wdata_nxt     = r_wdata_q;
        w_pselx_nxt     = 3'b000;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_hreadyout_nxt = 1'b1;
        case (r_state)
            ST_IDLE, ST_W_ENABLE, ST_R_ENABLE: begin
                if (w_valid && r_hreadyout) begin
                    w_addr_nxt      = bus.Haddr;
                    w_write_nxt     = bus.Hwrite;
                    w_hreadyout_nxt = 1'b0;
                    if (bus.Hwrite) begin
                        w_state_nxt = ST_WDATA;
                    end else begin
                        // Read setup goes out in the very next cycle, so the
                        // select/address come from the address-phase value.
                        w_state_nxt  = ST_R_SETUP;
                        w_pselx_nxt  = decode_sel(bus.Haddr);
                        w_pwrite_nxt = 1'b0;
                        w_paddr_nxt  = bus.Haddr;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WDATA: begin
                w_state_nxt     = ST_W_SETUP;
                w_wdata_nxt     = bus.Hwdata;
                w_pselx_nxt     = decode_sel(r_addr_q);
                w_pwrite_nxt    = 1'b1;
                w_paddr_nxt     = r_addr_q;
                w_pwdata_nxt    = bus.Hwdata;
                w_hreadyout_nxt = 1'b0;
            end
            ST_W_SETUP: begin
                w_state_nxt     = ST_W_ENABLE;
                w_pselx_nxt     = r_pselx;
                w_penable_nxt   = 1'b1;
                w_hreadyout_nxt = 1'b1;
            end
            ST_R_SETUP: begin
                w_state_nxt     = ST_R_ENABLE;
                w_pselx_nxt     = r_pselx;
                w_penable_nxt   = 1'b1;
                w_hreadyout_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_hreadyout_nxt = 1'b1;
            end
        endcase
    end

    // State, captured transfer and registered bus outputs.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_addr_q    <= 32'h0;
            r_write_q   <= 1'b0;
            r_wdata_q   <= 32'h0;
            r_pselx     <= 3'b000;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 32'h0;
            r_pwdata    <= 32'h0;
            r_hreadyout <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_q    <= w_addr_nxt;
            r_write_q   <= w_write_nxt;
            r_wdata_q   <= w_wdata_nxt;
            r_pselx     <= w_pselx_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_hreadyout <= w_hreadyout_nxt;
        end
    end

    // Read data is passed straight through from the peripheral in the enable cycle.
    always_comb begin
        if (r_state == ST_R_ENABLE) begin
            w_hrdata = bus.Prdata;
        end else begin
            w_hrdata = 32'h0;
        end
    end

    assign bus.Hrdata    = w_hrdata;
    assign bus.Hresp     = 2'b00;
    assign bus.Hreadyout = r_hreadyout;
    assign bus.Pselx     = r_pselx;
    assign bus.Penable   = r_penable;
    assign bus.Pwrite    = r_pwrite;
    assign bus.Paddr     = r_paddr;
    assign bus.Pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
// Purpose : directed self-checking bench for ahb_apb_bridge. Inputs change
//           1 ns after each rising edge; outputs are checked at that point
//           before new inputs are driven.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

    logic Hclk;
    logic Hresetn;
    int   n_total;
    int   n_pass;

    ahb_apb_bridge_if bus_if ();

    ahb_apb_bridge dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus_if.slave)
    );

    // 100 MHz clock.
    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.Htrans   = 2'b00;
        bus_if.Hreadyin = 1'b1;
    endtask

    // Single read: address phase in the current cycle, checks R_SETUP and R_ENABLE.
    task automatic read_xfer(input string tag, input logic [31:0] addr,
                             input logic [2:0] sel, input logic [31:0] rdata);
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = addr;
        bus_if.Hwrite = 1'b0;
        bus_if.Prdata = rdata;
        step();
        chk({tag, "_setup_psel"},    {29'd0, bus_if.Pselx}, {29'd0, sel});
        chk({tag, "_setup_penable"}, {31'd0, bus_if.Penable}, 32'd0);
        chk({tag, "_setup_paddr"},   bus_if.Paddr, addr);
        chk({tag, "_setup_pwrite"},  {31'd0, bus_if.Pwrite}, 32'd0);
        chk({tag, "_setup_hready"},  {31'd0, bus_if.Hreadyout}, 32'd0);
        chk({tag, "_setup_hrdata"},  bus_if.Hrdata, 32'h0);
        bus_idle();
        step();
        chk({tag, "_en_psel"},    {29'd0, bus_if.Pselx}, {29'd0, sel});
        chk({tag, "_en_penable"}, {31'd0, bus_if.Penable}, 32'd1);
        chk({tag, "_en_hready"},  {31'd0, bus_if.Hreadyout}, 32'd1);
        chk({tag, "_en_hrdata"},  bus_if.Hrdata, rdata);
        chk({tag, "_en_hresp"},   {30'd0, bus_if.Hresp}, 32'd0);
        step();
        chk({tag, "_after_psel"},   {29'd0, bus_if.Pselx}, 32'd0);
        chk({tag, "_after_hrdata"}, bus_if.Hrdata, 32'h0);
    endtask

    // Directed sequence.
    initial begin
        n_total         = 0;
        n_pass          = 0;
        Hresetn         = 1'b0;
        bus_if.Htrans   = 2'b00;
        bus_if.Haddr    = 32'h0;
        bus_if.Hwrite   = 1'b0;
        bus_if.Hwdata   = 32'h0;
        bus_if.Hreadyin = 1'b1;
        bus_if.Prdata   = 32'h0;
        #12;
        chk("rst_psel",    {29'd0, bus_if.Pselx}, 32'd0);
        chk("rst_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("rst_hready",  {31'd0, bus_if.Hreadyout}, 32'd1);
        chk("rst_hresp",   {30'd0, bus_if.Hresp}, 32'd0);
        chk("rst_hrdata",  bus_if.Hrdata, 32'h0);
        chk("rst_paddr",   bus_if.Paddr, 32'h0);
        chk("rst_pwdata",  bus_if.Pwdata, 32'h0);
        chk("rst_pwrite",  {31'd0, bus_if.Pwrite}, 32'd0);
        Hresetn = 1'b1;
        step();

        // Single write to 8000_0001, data A3.
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = 32'h8000_0001;
        bus_if.Hwrite = 1'b1;
        step();
        chk("wr_c1_hready", {31'd0, bus_if.Hreadyout}, 32'd0);
        chk("wr_c1_psel",   {29'd0, bus_if.Pselx}, 32'd0);
        bus_idle();
        bus_if.Hwdata = 32'h0000_00A3;
        step();
        chk("wr_c2_psel",    {29'd0, bus_if.Pselx}, 32'd1);
        chk("wr_c2_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("wr_c2_hready",  {31'd0, bus_if.Hreadyout}, 32'd0);
        chk("wr_c2_paddr",   bus_if.Paddr, 32'h8000_0001);
        chk("wr_c2_pwdata",  bus_if.Pwdata, 32'h0000_00A3);
        chk("wr_c2_pwrite",  {31'd0, bus_if.Pwrite}, 32'd1);
        bus_if.Hwdata = 32'hFFFF_FFFF;
        step();
        chk("wr_c3_psel",    {29'd0, bus_if.Pselx}, 32'd1);
        chk("wr_c3_penable", {31'd0, bus_if.Penable}, 32'd1);
        chk("wr_c3_hready",  {31'd0, bus_if.Hreadyout}, 32'd1);
        chk("wr_c3_pwdata",  bus_if.Pwdata, 32'h0000_00A3);
        step();
        chk("wr_c4_psel",    {29'd0, bus_if.Pselx}, 32'd0);
        chk("wr_c4_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("wr_c4_paddr",   bus_if.Paddr, 32'h8000_0001);

        // Reads and peripheral decode.
        read_xfer("rd0", 32'h8000_00A2, 3'b001, 32'hDEAD_BEEF);
        read_xfer("rd1", 32'h8400_0010, 3'b010, 32'h1111_2222);
        read_xfer("rd2", 32'h8800_0020, 3'b100, 32'h3333_4444);

        // Ignored transfers: out of range, BUSY, Hreadyin low.
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = 32'h9000_0000;
        bus_if.Hwrite = 1'b0;
        step();
        chk("oor_psel",   {29'd0, bus_if.Pselx}, 32'd0);
        chk("oor_hready", {31'd0, bus_if.Hreadyout}, 32'd1);
        chk("oor_hresp",  {30'd0, bus_if.Hresp}, 32'd0);
        bus_if.Htrans = 2'b01;
        bus_if.Haddr  = 32'h8000_0000;
        step();
        chk("busy_psel",   {29'd0, bus_if.Pselx}, 32'd0);
        chk("busy_hready", {31'd0, bus_if.Hreadyout}, 32'd1);
        bus_if.Htrans   = 2'b10;
        bus_if.Hreadyin = 1'b0;
        step();
        chk("nordy_psel",   {29'd0, bus_if.Pselx}, 32'd0);
        chk("nordy_hready", {31'd0, bus_if.Hreadyout}, 32'd1);
        bus_idle();
        step();
        chk("nordy_idle_psel", {29'd0, bus_if.Pselx}, 32'd0);

        // Back-to-back: write 8000_0004 then read 8400_0008 during W_ENABLE.
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = 32'h8000_0004;
        bus_if.Hwrite = 1'b1;
        step();
        bus_idle();
        bus_if.Hwdata = 32'h0000_55AA;
        step();
        chk("b2b_wsetup_psel", {29'd0, bus_if.Pselx}, 32'd1);
        step();
        chk("b2b_wen_penable", {31'd0, bus_if.Penable}, 32'd1);
        chk("b2b_wen_pwdata",  bus_if.Pwdata, 32'h0000_55AA);
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = 32'h8400_0008;
        bus_if.Hwrite = 1'b0;
        bus_if.Prdata = 32'h1234_5678;
        step();
        chk("b2b_rsetup_psel",    {29'd0, bus_if.Pselx}, 32'd2);
        chk("b2b_rsetup_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("b2b_rsetup_paddr",   bus_if.Paddr, 32'h8400_0008);
        chk("b2b_rsetup_pwrite",  {31'd0, bus_if.Pwrite}, 32'd0);
        chk("b2b_rsetup_hready",  {31'd0, bus_if.Hreadyout}, 32'd0);
        bus_idle();
        step();
        chk("b2b_ren_penable", {31'd0, bus_if.Penable}, 32'd1);
        chk("b2b_ren_hrdata",  bus_if.Hrdata, 32'h1234_5678);
        chk("b2b_ren_hready",  {31'd0, bus_if.Hreadyout}, 32'd1);
        step();

        // Asynchronous reset in the middle of W_SETUP.
        bus_if.Htrans = 2'b10;
        bus_if.Haddr  = 32'h8800_0000;
        bus_if.Hwrite = 1'b1;
        step();
        bus_idle();
        bus_if.Hwdata = 32'h0000_0077;
        step();
        chk("rstmid_pre_psel", {29'd0, bus_if.Pselx}, 32'd4);
        #1 Hresetn = 1'b0;
        #1;
        chk("rstmid_psel",    {29'd0, bus_if.Pselx}, 32'd0);
        chk("rstmid_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("rstmid_hready",  {31'd0, bus_if.Hreadyout}, 32'd1);
        chk("rstmid_paddr",   bus_if.Paddr, 32'h0);
        #2 Hresetn = 1'b1;
        step();
        chk("rstmid_after_psel",    {29'd0, bus_if.Pselx}, 32'd0);
        chk("rstmid_after_penable", {31'd0, bus_if.Penable}, 32'd0);
        chk("rstmid_after_hready",  {31'd0, bus_if.Hreadyout}, 32'd1);
        read_xfer("rd3", 32'h8000_0010, 3'b001, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
